shift_stage: RTL and testbench

Two-stage, valid/ready-handshaked execute-pipeline wrapper around the 16-bit shift datapath. It accepts an operand, a shift count, an opcode and a destination register tag from decode/issue. It computes ROL/SLL/ROR/SRL through a combinational shift core and presents a registered result to write-back. It decouples issue from write-back stalls, supports pipeline flush, and sustains one operation per cycle.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_stage_if.sv | 32 +++
 rtl/shift_srl.sv | 15 +
 rtl/shift_stage_core.sv | 44 ++++
 rtl/shift_stage.sv | 113 +++++++++++
 tb/tb_shift_stage.sv | 188 ++++++++++++++++++
 6 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared widths, opcode encodings and the per-stage occupancy
// state used by the shift execute stage and its shift core.
// No ports (package).
package shift_pkg;

  localparam int N = 16;  // data width
  localparam int C = 4;   // shift-count width (log2 N)
  localparam int T = 3;   // destination tag width

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  // A pipeline stage is either holding an op or not; nothing else.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_st_t;

endpackage

// File: rtl/shift_stage_if.sv
// shift_stage_if: issue-side and write-back-side handshake bundle of the
// shift execute stage.
//   in_valid/in_ready/in_data/in_cnt/in_op/in_dst : issue -> stage
//   out_valid/out_ready/out_data/out_dst          : stage -> write-back
//   occupancy                                     : number of full stages
// Modports: master = issue/write-back environment, slave = the stage.
interface shift_stage_if;
  import shift_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [C-1:0] in_cnt;
  logic [1:0]   in_op;
  logic [T-1:0] in_dst;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [T-1:0] out_dst;
  logic [1:0]   occupancy;

  modport master (
    output in_valid, in_data, in_cnt, in_op, in_dst, out_ready,
    input  in_ready, out_valid, out_data, out_dst, occupancy
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, in_dst, out_ready,
    output in_ready, out_valid, out_data, out_dst, occupancy
  );

endinterface

// File: rtl/shift_srl.sv
// shift_srl: logical right shifter, zero fill.
//   i_data : operand
//   i_cnt  : shift amount
//   o_data : i_data shifted right by i_cnt
module shift_srl
  import shift_pkg::*;
(
  input  logic [N-1:0] i_data,
  input  logic [C-1:0] i_cnt,
  output logic [N-1:0] o_data
);

  assign o_data = i_data >> i_cnt;

endmodule

// File: rtl/shift_stage_core.sv
// shift_core: purely combinational 16-bit shift datapath.
//   i_data   : operand
//   i_cnt    : shift amount 0..N-1
//   i_op     : OP_ROL / OP_SLL / OP_ROR / OP_SRL
//   o_result : shifted result (count 0 passes data unchanged)
module shift_core
  import shift_pkg::*;
(
  input  logic [N-1:0] i_data,
  input  logic [C-1:0] i_cnt,
  input  logic [1:0]   i_op,
  output logic [N-1:0] o_result
);

  logic [N-1:0] w_sll;
  logic [N-1:0] w_srl;
  logic [N-1:0] w_rol;
  logic [N-1:0] w_ror;

  assign w_sll = i_data << i_cnt;
  // The complementary shift by N - cnt is N when cnt = 0, which yields zero,
  // so the rotates degenerate cleanly to a pass-through.
  assign w_rol = (i_data << i_cnt) | (i_data >> (N - int'(i_cnt)));
  assign w_ror = (i_data >> i_cnt) | (i_data << (N - int'(i_cnt)));

  shift_srl u_srl (
    .i_data (i_data),
    .i_cnt  (i_cnt),
    .o_data (w_srl)
  );

  // Opcode select of the shift result.
  always_comb begin
    o_result = {N{1'b0}};
    case (i_op)
      OP_ROL:  o_result = w_rol;
      OP_SLL:  o_result = w_sll;
      OP_ROR:  o_result = w_ror;
      OP_SRL:  o_result = w_srl;
      default: o_result = {N{1'b0}};
    endcase
  end

endmodule

// File: rtl/shift_stage.sv
// shift_stage: two-stage valid/ready execute wrapper around shift_core.
// S1 registers the issued operand, S2 registers the shifted result.
//   i_clk   : rising-edge clock
//   i_rst   : asynchronous active-high reset
//   i_flush : synchronous kill of all in-flight ops
//   io_bus  : shift_stage_if.slave (issue handshake, write-back handshake,
//             occupancy)
module shift_stage
  import shift_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  shift_stage_if.slave  io_bus
);

  stage_st_t    r_s1_st;
  stage_st_t    r_s2_st;
  stage_st_t    w_s1_st_nxt;
  stage_st_t    w_s2_st_nxt;
  logic [N-1:0] r_s1_data;
  logic [C-1:0] r_s1_cnt;
  logic [1:0]   r_s1_op;
  logic [T-1:0] r_s1_dst;
  logic [N-1:0] r_s2_res;
  logic [T-1:0] r_s2_dst;
  logic [1:0]   r_occ;
  logic [1:0]   w_occ_nxt;
  logic         w_s2_adv;
  logic         w_in_ready;
  logic         w_s1_load;
  logic [N-1:0] w_core_res;

  // S2 can take a new value when it is empty or its result leaves this cycle;
  // this is the only combinational path from out_ready to in_ready.
  assign w_s2_adv   = (r_s2_st == ST_EMPTY) | io_bus.out_ready;
  assign w_in_ready = ~i_rst & ~i_flush & ((r_s1_st == ST_EMPTY) | w_s2_adv);
  assign w_s1_load  = io_bus.in_valid & w_in_ready;

  shift_core u_core (
    .i_data   (r_s1_data),
    .i_cnt    (r_s1_cnt),
    .i_op     (r_s1_op),
    .o_result (w_core_res)
  );

  // Next-state of both stage occupancy flags and the registered occupancy.
  always_comb begin
    w_s1_st_nxt = r_s1_st;
    w_s2_st_nxt = r_s2_st;
    if (i_flush) begin
      w_s1_st_nxt = ST_EMPTY;
      w_s2_st_nxt = ST_EMPTY;
    end else begin
      if (w_s2_adv) begin
        w_s2_st_nxt = r_s1_st;
      end else begin
        w_s2_st_nxt = r_s2_st;
      end
      if (w_s1_load) begin
        w_s1_st_nxt = ST_FULL;
      end else if (w_s2_adv) begin
        w_s1_st_nxt = ST_EMPTY;
      end else begin
        w_s1_st_nxt = r_s1_st;
      end
    end
    w_occ_nxt = {1'b0, (w_s1_st_nxt == ST_FULL)} + {1'b0, (w_s2_st_nxt == ST_FULL)};
  end

  // Stage state and occupancy registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_st <= ST_EMPTY;
      r_s2_st <= ST_EMPTY;
      r_occ   <= 2'd0;
    end else begin
      r_s1_st <= w_s1_st_nxt;
      r_s2_st <= w_s2_st_nxt;
      r_occ   <= w_occ_nxt;
    end
  end

  // Operand and result registers; contents only matter while the stage is full.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_data <= {N{1'b0}};
      r_s1_cnt  <= {C{1'b0}};
      r_s1_op   <= 2'b00;
      r_s1_dst  <= {T{1'b0}};
      r_s2_res  <= {N{1'b0}};
      r_s2_dst  <= {T{1'b0}};
    end else begin
      if (w_s1_load) begin
        r_s1_data <= io_bus.in_data;
        r_s1_cnt  <= io_bus.in_cnt;
        r_s1_op   <= io_bus.in_op;
        r_s1_dst  <= io_bus.in_dst;
      end
      if (w_s2_adv) begin
        r_s2_res <= w_core_res;
        r_s2_dst <= r_s1_dst;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = (r_s2_st == ST_FULL);
  assign io_bus.out_data  = r_s2_res;
  assign io_bus.out_dst   = r_s2_dst;
  assign io_bus.occupancy = r_occ;

endmodule

// File: tb/tb_shift_stage.sv
// tb_shift_stage: directed and randomized bench for shift_stage. Ops in
// flight are tracked in a queue; results are computed arithmetically.
module tb_shift_stage;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  shift_stage_if u_if ();

  shift_stage u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .io_bus  (u_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  dst;
    int          acc;   // edge number at which the op was accepted
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   accepted;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Rotates and shifts expressed as multiplication/division by powers of two.
  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] c,
                                            input logic [1:0] op);
    longint dv, p, r;
    dv = longint'(d);
    p  = longint'(1) << c;
    case (op)
      2'b00:   r = (dv * p) % 65536 + dv / (65536 / p);
      2'b01:   r = (dv * p) % 65536;
      2'b10:   r = dv / p + (dv * (65536 / p)) % 65536;
      default: r = dv / p;
    endcase
    return r[15:0];
  endfunction

  // One clock: drive, check at negedge, update the model, advance.
  task automatic step(input bit v, input logic [15:0] d, input logic [3:0] c,
                      input logic [1:0] op, input logic [2:0] dst, input logic [15:0] exp,
                      input bit ordy, input bit fl);
    bit er, eo;
    u_if.in_valid  = v;
    u_if.in_data   = d;
    u_if.in_cnt    = c;
    u_if.in_op     = op;
    u_if.in_dst    = dst;
    u_if.out_ready = ordy;
    flush          = fl;
    @(negedge clk);
    er = !fl && (q.size() < 2 || ordy);
    eo = (q.size() > 0) && (cyc > q[0].acc);
    check_val("in_ready", u_if.in_ready, er);
    check_val("out_valid", u_if.out_valid, eo);
    check_val("occupancy", u_if.occupancy, q.size());
    if (eo) begin
      check_val("out_data", u_if.out_data, q[0].res);
      check_val("out_dst", u_if.out_dst, q[0].dst);
      if (ordy) void'(q.pop_front());
    end
    accepted = 1'b0;
    if (fl) begin
      q.delete();
    end else if (v && er) begin
      q.push_back('{exp, dst, cyc + 1});
      accepted = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [1:0] op,
                      input logic [2:0] dst, input logic [15:0] exp, input bit ordy);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step(1'b1, d, c, op, dst, exp, ordy, 1'b0);
      done = accepted;
    end
    if (!done) check_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++)
      step(1'b0, 16'h0, 4'h0, 2'b00, 3'h0, 16'h0, 1'b1, 1'b0);
    check_val("drain", q.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  rc;
    logic [1:0]  rop;
    logic [2:0]  rdst;

    rst = 1'b1;
    flush = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_data = 16'h0; u_if.in_cnt = 4'h0;
    u_if.in_op = 2'b00; u_if.in_dst = 3'h0; u_if.out_ready = 1'b1;
    #2;
    check_val("rst_in_ready", u_if.in_ready, 32'd0);
    check_val("rst_out_valid", u_if.out_valid, 32'd0);
    check_val("rst_out_data", u_if.out_data, 32'd0);
    check_val("rst_out_dst", u_if.out_dst, 32'd0);
    check_val("rst_occupancy", u_if.occupancy, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic ops and boundary counts, streamed with out_ready high.
    send(16'h8001, 4'd1,  OP_SRL, 3'd1, 16'h4000, 1'b1);
    send(16'h8001, 4'd4,  OP_SLL, 3'd2, 16'h0010, 1'b1);
    send(16'h8001, 4'd1,  OP_ROL, 3'd3, 16'h0003, 1'b1);
    send(16'h0001, 4'd4,  OP_ROR, 3'd4, 16'h1000, 1'b1);
    send(16'hA5C3, 4'd0,  OP_ROL, 3'd5, 16'hA5C3, 1'b1);
    send(16'hA5C3, 4'd0,  OP_SLL, 3'd6, 16'hA5C3, 1'b1);
    send(16'hA5C3, 4'd0,  OP_ROR, 3'd7, 16'hA5C3, 1'b1);
    send(16'hA5C3, 4'd0,  OP_SRL, 3'd0, 16'hA5C3, 1'b1);
    send(16'hFFFF, 4'd15, OP_SRL, 3'd1, 16'h0001, 1'b1);
    send(16'h8000, 4'd15, OP_ROL, 3'd2, 16'h4000, 1'b1);
    drain();

    // Back-pressure: two accepted, third held off while write-back stalls.
    send(16'h1234, 4'd3, OP_SLL, 3'd1, 16'h91A0, 1'b0);
    send(16'h1234, 4'd4, OP_ROR, 3'd2, 16'h4123, 1'b0);
    repeat (3) step(1'b1, 16'h00F0, 4'd4, OP_SRL, 3'd3, 16'h000F, 1'b0, 1'b0);
    check_val("bp_held_off", accepted, 32'd0);
    send(16'h00F0, 4'd4, OP_SRL, 3'd3, 16'h000F, 1'b1);
    send(16'h0F00, 4'd8, OP_ROL, 3'd4, 16'h000F, 1'b1);
    drain();

    // Flush with two ops in flight and a new op offered.
    send(16'h1111, 4'd1, OP_SLL, 3'd1, 16'h2222, 1'b0);
    send(16'h2222, 4'd1, OP_SRL, 3'd2, 16'h1111, 1'b0);
    step(1'b1, 16'h3333, 4'd2, OP_ROL, 3'd3, 16'hCCCC, 1'b0, 1'b1);
    check_val("flush_not_accepted", accepted, 32'd0);
    send(16'h4444, 4'd2, OP_ROR, 3'd4, 16'h1111, 1'b1);
    drain();

    // Asynchronous reset with both stages full.
    send(16'h5555, 4'd1, OP_SLL, 3'd5, 16'hAAAA, 1'b0);
    send(16'h6666, 4'd1, OP_SRL, 3'd6, 16'h3333, 1'b0);
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_out_valid", u_if.out_valid, 32'd0);
    check_val("mid_rst_occupancy", u_if.occupancy, 32'd0);
    check_val("mid_rst_in_ready", u_if.in_ready, 32'd0);
    q.delete();
    @(posedge clk);
    cyc++;
    #1 rst = 1'b0;
    send(16'h0180, 4'd7, OP_ROR, 3'd7, 16'h0003, 1'b1);
    drain();

    // Random valid/ready/flush stress.
    for (int i = 0; i < 500; i++) begin
      rd   = 16'($urandom);
      rc   = 4'($urandom_range(0, 15));
      rop  = 2'($urandom_range(0, 3));
      rdst = 3'($urandom_range(0, 7));
      step($urandom_range(0, 3) != 0, rd, rc, rop, rdst, ref_shift(rd, rc, rop),
           $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
